multiword_adder_seq: RTL and testbench

Multi-cycle wide-operand adder that feeds a single CHUNK-wide RippleCarryAdder instance one chunk per cycle, least-significant first, holding the inter-chunk carry in a register. It trades latency for area: a WIDTH-bit add costs one CHUNK-bit ripple chain plus operand and result shift registers. It sits between an operand-producing stage and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/multiword_adder_seq.sv | 151 +++++++++++++++
 tb/tb_multiword_adder_seq.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: WIDTH-bit adder that reuses one CHUNK-bit ripple-carry
// adder over WIDTH/CHUNK cycles, least-significant chunk first, with the
// inter-chunk carry held in a register. WIDTH must be a positive multiple of CHUNK.

// RippleCarryAdder: plain N-bit ripple-carry adder, one full-adder cell per bit.
module RippleCarryAdder #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_ci,
    output logic [N-1:0] o_sum,
    output logic         o_co
);

    // Carry ripples from bit 0 upward through one full-adder cell per bit
    always_comb begin : ripple
        logic v_c;
        v_c   = i_ci;
        o_sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ v_c;
            v_c      = (i_a[i] & i_b[i]) | (v_c & (i_a[i] ^ i_b[i]));
        end
        o_co = v_c;
    end

endmodule

module multiword_adder_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_co;
    logic [IDX_W-1:0] r_idx;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_co;
    logic             w_accept;
    logic             w_last;
    logic             w_transfer;

    // Handshake/control qualifiers derived from the registered state
    always_comb begin
        w_accept   = (r_state == S_IDLE) && in_valid;
        w_last     = (r_state == S_RUN) && (r_idx == LAST_IDX);
        w_transfer = (r_state == S_DONE) && out_ready;
    end

    // The single shared chunk adder always looks at the low chunk of the operands
    RippleCarryAdder #(
        .N(CHUNK)
    ) u_rca (
        .i_a  (r_op1[CHUNK-1:0]),
        .i_b  (r_op2[CHUNK-1:0]),
        .i_ci (r_carry),
        .o_sum(w_chunk_sum),
        .o_co (w_chunk_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)   w_state_next = S_RUN;
            S_RUN:  if (w_last)     w_state_next = S_DONE;
            S_DONE: if (w_transfer) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand/result shift registers, inter-chunk carry and chunk index.
    // The result chunk is OR-ed in at the top via a shift so the same
    // expression stays legal when CHUNK == WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op1   <= '0;
            r_op2   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_op1   <= in1;
            r_op2   <= in2;
            r_carry <= ci;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_op1   <= r_op1 >> CHUNK;
            r_op2   <= r_op2 >> CHUNK;
            r_sum   <= (r_sum >> CHUNK) | (WIDTH'(w_chunk_sum) << (WIDTH - CHUNK));
            r_carry <= w_chunk_co;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_co <= w_chunk_co;
            end
        end
    end

    assign sum = r_sum;
    assign co  = r_co;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq: a 64/16 instance for the main
// scenarios and an 8/8 instance for the single-chunk case. Expected results
// are pushed to scoreboard queues on accept and popped on output transfer.
module tb_multiword_adder_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        co;

    logic        d8_in_valid;
    logic        d8_in_ready;
    logic [7:0]  d8_in1;
    logic [7:0]  d8_in2;
    logic        d8_ci;
    logic        d8_out_valid;
    logic        d8_out_ready;
    logic [7:0]  d8_sum;
    logic        d8_co;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [64:0] sb_q[$];
    logic [8:0]  sb8_q[$];

    multiword_adder_seq #(
        .WIDTH(64),
        .CHUNK(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .ci       (ci),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .co       (co)
    );

    multiword_adder_seq #(
        .WIDTH(8),
        .CHUNK(8)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (d8_in_valid),
        .in_ready (d8_in_ready),
        .in1      (d8_in1),
        .in2      (d8_in2),
        .ci       (d8_ci),
        .out_valid(d8_out_valid),
        .out_ready(d8_out_ready),
        .sum      (d8_sum),
        .co       (d8_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait (bounded) for in_ready, record the expected result
    // and let the accepting edge pass. ok=0 if in_ready never came.
    task automatic accept64(input logic [63:0] a, input logic [63:0] b, input logic c,
                            output bit ok);
        int n;
        n = 0;
        in1 = a;
        in2 = b;
        ci = c;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        ok = in_ready;
        if (ok) begin
            sb_q.push_back({1'b0, a} + {1'b0, b} + {64'd0, c});
            step();
        end
        in_valid = 1'b0;
    endtask

    // Count cycles from the current sample point until out_valid (bounded).
    task automatic wait_valid64(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if ({in_ready, out_valid, co, sum} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset64: got rdy=%b vld=%b co=%b sum=%h, expected rdy=1 vld=0 co=0 sum=0",
                     in_ready, out_valid, co, sum);
        end
        n_tests++;
        if ({d8_in_ready, d8_out_valid, d8_co, d8_sum} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset8: got rdy=%b vld=%b co=%b sum=%h, expected rdy=1 vld=0 co=0 sum=0",
                     d8_in_ready, d8_out_valid, d8_co, d8_sum);
        end
        rst_n = 1'b1;
        step();
    endtask

    // One directed transaction: latency must be 4 cycles, result from scoreboard.
    task automatic run_directed(input string name, input logic [63:0] a, input logic [63:0] b,
                                input logic c);
        bit          ok;
        int          cyc;
        logic [64:0] exp_v;
        accept64(a, b, c, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept: got in_ready=%b, expected 1", name, in_ready);
        end else begin
            wait_valid64(cyc);
            n_tests++;
            if (cyc != 4) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d cycles, expected 4", name, cyc);
            end
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({co, sum} !== exp_v) begin
                n_fail++;
                $display("FAIL %s_result: got %h, expected %h", name, {co, sum}, exp_v);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            n_tests++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL %s_release: got rdy=%b vld=%b, expected rdy=1 vld=0",
                         name, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_full_carry();
        run_directed("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    endtask

    task automatic test_carry_in();
        run_directed("carry_in_a", 64'h0000_FFFF_0000_FFFF, 64'd0, 1'b1);
        run_directed("carry_in_b", 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b1);
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          cyc;
        logic [64:0] exp_v;
        accept64(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, ok);
        wait_valid64(cyc);
        n_tests++;
        if (!ok || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: got ok=%b vld=%b, expected ok=1 vld=1", ok, out_valid);
        end else begin
            exp_v = sb_q.pop_front();
            out_ready = 1'b0;
            in1 = 64'hAAAA_AAAA_AAAA_AAAA;
            in2 = 64'h5555_5555_5555_5555;
            ci = 1'b1;
            in_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                step();
                n_tests++;
                if ({out_valid, in_ready, co, sum} !== {1'b1, 1'b0, exp_v}) begin
                    n_fail++;
                    $display("FAIL bp_hold: got vld=%b rdy=%b res=%h, expected vld=1 rdy=0 res=%h",
                             out_valid, in_ready, {co, sum}, exp_v);
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            n_tests++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL bp_no_early_accept: got rdy=%b vld=%b, expected rdy=1 vld=0",
                         in_ready, out_valid);
            end
            sb_q.push_back({1'b0, in1} + {1'b0, in2} + {64'd0, ci});
            step();
            in_valid = 1'b0;
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_second_accept: got rdy=%b, expected 0", in_ready);
            end
            wait_valid64(cyc);
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({out_valid, co, sum} !== {1'b1, exp_v}) begin
                n_fail++;
                $display("FAIL bp_second_result: got vld=%b res=%h, expected vld=1 res=%h",
                         out_valid, {co, sum}, exp_v);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        bit          seen;
        logic [64:0] dropped;
        accept64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, ok);
        if (ok) dropped = sb_q.pop_back();
        seen = 1'b0;
        step();
        step();
        if (out_valid) seen = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if ({in_ready, out_valid, co, sum} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_state: got rdy=%b vld=%b co=%b sum=%h, expected rdy=1 vld=0 co=0 sum=0",
                     in_ready, out_valid, co, sum);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_valid: got out_valid pulse=1, expected 0");
        end
        run_directed("reset_mid_5p7", 64'd5, 64'd7, 1'b0);
    endtask

    task automatic test_back_to_back();
        int          accepts;
        int          results;
        int          cyc;
        int          last_acc;
        bit          acc;
        bit          res;
        logic [64:0] exp_v;
        accepts = 0;
        results = 0;
        cyc = 0;
        last_acc = -1;
        in1 = {$urandom, $urandom};
        in2 = {$urandom, $urandom};
        ci = 1'($urandom_range(1));
        in_valid = 1'b1;
        out_ready = 1'b1;
        while ((accepts < 1000 || results < 1000) && cyc < 7000) begin
            acc = in_valid && in_ready;
            res = out_valid;
            if (res) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected: got out_valid with empty scoreboard, expected none");
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({co, sum} !== exp_v) begin
                        n_fail++;
                        $display("FAIL b2b_result: got %h, expected %h", {co, sum}, exp_v);
                    end
                end
                results++;
            end
            if (acc) begin
                sb_q.push_back({1'b0, in1} + {1'b0, in2} + {64'd0, ci});
                if (last_acc >= 0) begin
                    n_tests++;
                    if (cyc - last_acc != 6) begin
                        n_fail++;
                        $display("FAIL b2b_interval: got %0d cycles, expected 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            step();
            cyc++;
            if (acc) begin
                in1 = {$urandom, $urandom};
                in2 = {$urandom, $urandom};
                ci = 1'($urandom_range(1));
                if (accepts == 1000) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (accepts != 1000 || results != 1000 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got accepts=%0d results=%0d pending=%0d, expected 1000 1000 0",
                     accepts, results, sb_q.size());
        end
    endtask

    task automatic test_degenerate();
        int         n;
        int         cyc;
        logic [8:0] exp_v;
        n = 0;
        d8_in1 = 8'h80;
        d8_in2 = 8'h80;
        d8_ci = 1'b0;
        d8_in_valid = 1'b1;
        while (!d8_in_ready && n < 20) begin
            step();
            n++;
        end
        n_tests++;
        if (d8_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL d8_accept: got in_ready=%b, expected 1", d8_in_ready);
        end else begin
            sb8_q.push_back({1'b0, d8_in1} + {1'b0, d8_in2} + {8'd0, d8_ci});
            step();
            d8_in_valid = 1'b0;
            cyc = 0;
            while (!d8_out_valid && cyc < 20) begin
                step();
                cyc++;
            end
            n_tests++;
            if (cyc != 1) begin
                n_fail++;
                $display("FAIL d8_latency: got %0d cycles, expected 1", cyc);
            end
            exp_v = sb8_q.pop_front();
            n_tests++;
            if ({d8_co, d8_sum} !== exp_v) begin
                n_fail++;
                $display("FAIL d8_result: got %h, expected %h", {d8_co, d8_sum}, exp_v);
            end
            d8_out_ready = 1'b1;
            step();
            d8_out_ready = 1'b0;
            n_tests++;
            if ({d8_in_ready, d8_out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL d8_release: got rdy=%b vld=%b, expected rdy=1 vld=0",
                         d8_in_ready, d8_out_valid);
            end
        end
        d8_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        ci = 1'b0;
        out_ready = 1'b0;
        d8_in_valid = 1'b0;
        d8_in1 = '0;
        d8_in2 = '0;
        d8_ci = 1'b0;
        d8_out_ready = 1'b0;
        test_reset();
        test_full_carry();
        test_carry_in();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_degenerate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
